read_fifo: RTL and testbench

// - Drains a programmed number of lines from the read port of a fifobram FIFO.
// - Issues each line as a write pulse (we + wdata) to a downstream internal consumer.
// - Honours the consumer's almostfull backpressure.
// - Paired with the FIFO write-side loader: that block fills the FIFO, this block empties it.
// - Sits between the BRAM FIFO and the internal read interface of compute/memory-write engines.

---
 rtl/pipearch_common.sv | 14 +
 rtl/read_fifo_skid.sv | 55 +++++
 rtl/read_fifo.sv | 124 ++++++++++++
 tb/tb_read_fifo.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipearch_common.sv
// Types shared by the pipeline-architecture FIFO read/write engines.
package pipearch_common;

  localparam int unsigned COUNT_W = 16;

  typedef logic [COUNT_W-1:0] t_count;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_READ  = 2'd1,
    STATE_DRAIN = 2'd2
  } t_readstate;

endpackage

// File: rtl/read_fifo_skid.sv
// Small register FIFO that catches returning BRAM read data; first-word-fall-through
// with a same-cycle bypass so a push can be popped in the cycle it arrives.
module read_fifo_skid #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic [DATA_WIDTH-1:0]              din,
  input  logic                               pop,
  output logic [DATA_WIDTH-1:0]              head_c,
  output logic [$clog2(SKID_DEPTH+1)-1:0]    count,
  output logic                               empty_c
);

  localparam int unsigned CW = $clog2(SKID_DEPTH + 1);
  localparam int unsigned AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic                  stored_c;
  logic                  wr_c;
  logic                  rd_c;

  assign stored_c = (count != '0);
  assign empty_c  = !stored_c && !push;
  assign head_c   = stored_c ? mem[rd_ptr] : din;
  // A push popped while nothing is stored bypasses the array entirely.
  assign rd_c     = pop && stored_c;
  assign wr_c     = push && (stored_c || !pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_c) wr_ptr <= (wr_ptr == AW'(SKID_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (rd_c) rd_ptr <= (rd_ptr == AW'(SKID_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (wr_c && !rd_c)      count <= count + CW'(1);
      else if (!wr_c && rd_c) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= din;
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(pop && empty_c));
  a_no_overflow:  assert property (@(posedge clk) disable iff (!reset)
                                   !(wr_c && !rd_c && count == CW'(SKID_DEPTH)));

endmodule

// File: rtl/read_fifo.sv
// Drains a programmed number of lines from a BRAM FIFO into a write-pulse consumer,
// honouring almostfull backpressure with credit-limited reads into a skid buffer.
module read_fifo
  import pipearch_common::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  input  logic [31:0]           configreg,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  out_we,
  output logic [DATA_WIDTH-1:0] out_wdata,
  input  logic                  out_almostfull,
  output logic                  op_done,
  output logic                  busy
);

  localparam int unsigned SCW = $clog2(SKID_DEPTH + 1);
  localparam int unsigned CRW = $clog2(SKID_DEPTH + RD_LATENCY + 2) + 1;

  t_readstate             state;
  t_count                 len;
  t_count                 issued;
  t_count                 sent;
  logic [RD_LATENCY-1:0]  rd_valid;
  logic [SCW-1:0]         skid_count;
  logic                   skid_empty_c;
  logic [DATA_WIDTH-1:0]  skid_head_c;
  logic [CRW-1:0]         credit_c;
  logic                   rd_accept_c;
  logic                   issue_c;
  logic                   pop_c;
  logic                   unused_cfg_c;

  assign unused_cfg_c = ^configreg[15:0];

  read_fifo_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .push    (rd_valid[RD_LATENCY-1]),
    .din     (fifo_rdata),
    .pop     (pop_c),
    .head_c  (skid_head_c),
    .count   (skid_count),
    .empty_c (skid_empty_c)
  );

  // Slots already claimed: stored lines, reads in the return pipe, and the read now on the bus.
  always_comb begin
    credit_c = CRW'(skid_count) + CRW'(fifo_re);
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      credit_c = credit_c + CRW'(rd_valid[i]);
    end
  end

  // A read presented to an empty FIFO is dropped by the FIFO, so only accepted reads count.
  assign rd_accept_c = fifo_re && !fifo_empty;
  assign issue_c     = (state == STATE_READ) && !fifo_empty
                       && ((17'(issued) + 17'(fifo_re)) < 17'(len))
                       && (credit_c < CRW'(SKID_DEPTH));
  assign pop_c       = !skid_empty_c && !out_almostfull;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= STATE_IDLE;
      len       <= '0;
      issued    <= '0;
      sent      <= '0;
      rd_valid  <= '0;
      fifo_re   <= 1'b0;
      out_we    <= 1'b0;
      out_wdata <= '0;
      op_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      fifo_re  <= issue_c;
      rd_valid <= (rd_valid << 1) | RD_LATENCY'(rd_accept_c);
      out_we   <= pop_c;
      op_done  <= 1'b0;
      if (pop_c) begin
        out_wdata <= skid_head_c;
        sent      <= sent + 16'd1;
      end
      if (rd_accept_c) issued <= issued + 16'd1;

      unique case (state)
        STATE_IDLE: begin
          if (op_start) begin
            len    <= configreg[31:16];
            issued <= '0;
            sent   <= '0;
            if (configreg[31:16] == 16'd0) begin
              op_done <= 1'b1;
            end else begin
              state <= STATE_READ;
              busy  <= 1'b1;
            end
          end
        end
        STATE_READ: begin
          if (rd_accept_c && issued == len - 16'd1) state <= STATE_DRAIN;
        end
        STATE_DRAIN: begin
          if (sent == len && skid_empty_c) begin
            state   <= STATE_IDLE;
            busy    <= 1'b0;
            op_done <= 1'b1;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_fifo.sv
// Directed bench for read_fifo: table of single operations plus hand-written corner sequences.
module tb_read_fifo;
  import pipearch_common::*;

  localparam int unsigned DW = 64;
  localparam int unsigned RDL = 1;
  localparam int unsigned SKD = 4;

  logic          clk;
  logic          reset;
  logic          op_start;
  logic [31:0]   configreg;
  logic          fifo_re;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_empty;
  logic          out_we;
  logic [DW-1:0] out_wdata;
  logic          out_almostfull;
  logic          op_done;
  logic          busy;

  read_fifo #(.DATA_WIDTH(DW), .RD_LATENCY(RDL), .SKID_DEPTH(SKD)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .configreg(configreg),
    .fifo_re(fifo_re), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .out_we(out_we), .out_wdata(out_wdata), .out_almostfull(out_almostfull),
    .op_done(op_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Behavioural BRAM FIFO, read latency 1; reads while empty are ignored.
  logic [DW-1:0] fmem [256];
  int  wr_idx = 0;
  int  rd_idx = 0;
  int  next_seq = 0;
  int  head_seq = 0;
  logic flush = 1'b0;

  assign fifo_empty = (wr_idx == rd_idx);

  always @(posedge clk) begin
    if (flush) rd_idx <= wr_idx;
    else if (fifo_re && rd_idx != wr_idx) begin
      fifo_rdata <= fmem[rd_idx & 255];
      rd_idx     <= rd_idx + 1;
    end
  end

  function automatic logic [DW-1:0] line_val(input int n);
    return 64'hA5A5_0000_0000_0000 | 64'(n);
  endfunction

  // Output monitor: everything observed is recorded; comparisons use bench-side expectations.
  int   cyc = 0;
  logic [DW-1:0] got_q [$];
  int   got_cyc [$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   re_cnt = 0;
  int   busy_cnt = 0;
  logic prev_af = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_we) begin
      got_q.push_back(out_wdata);
      got_cyc.push_back(cyc);
      chk("af_slack", 64'(prev_af), 64'd0);
    end
    if (op_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (fifo_re) re_cnt++;
    if (busy) busy_cnt++;
    if (busy) chk("skid_bound", 64'(dut.u_skid.count <= SKD), 64'd1);
    prev_af = out_almostfull;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_lines(input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_idx & 255] = line_val(next_seq);
      next_seq++;
      wr_idx++;
    end
  endtask

  task automatic start_op(input int len, output int s);
    configreg = {16'(len), 16'hBEEF};
    op_start  = 1'b1;
    s         = cyc;
    tick();
    op_start  = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic check_lines(input string name, input int gb, input int n, input int first_seq);
    chk({name, "_nlines"}, 64'(got_q.size() - gb), 64'(n));
    for (int k = 0; k < n && gb + k < got_q.size(); k++)
      chk({name, "_data"}, got_q[gb + k], line_val(first_seq + k));
  endtask

  logic af_run = 1'b0;
  task automatic af_drive();
    int ph = 0;
    while (af_run) begin
      out_almostfull = (ph < 3);
      ph = (ph + 1) % 5;
      tick();
    end
    out_almostfull = 1'b0;
  endtask

  typedef struct {
    string name;
    int    len;
    int    prefill;
    bit    af;
    int    exp_first;  // out_we offset from op_start cycle, -1 = not checked
    int    exp_done;   // op_done offset from op_start cycle, -1 = not checked
  } vec_t;

  vec_t vecs [5];

  initial begin
    int s, s2, gb, db, rb, bb, n;

    vecs[0] = '{"len8",  8,  8,  1'b0, 4,  12};
    vecs[1] = '{"len0",  0,  0,  1'b0, -1, 1};
    vecs[2] = '{"af16",  16, 16, 1'b1, -1, -1};
    vecs[3] = '{"len1",  1,  1,  1'b0, 4,  5};
    vecs[4] = '{"len3",  3,  3,  1'b0, 4,  7};

    reset = 1'b0; op_start = 1'b0; configreg = '0; out_almostfull = 1'b0;
    repeat (3) tick();
    chk("rst_fifo_re", 64'(fifo_re), 64'd0);
    chk("rst_out_we", 64'(out_we), 64'd0);
    chk("rst_op_done", 64'(op_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wdata", out_wdata, 64'd0);
    reset = 1'b1;
    tick();

    for (int r = 0; r < 5; r++) begin
      push_lines(vecs[r].prefill);
      tick();
      gb = got_q.size(); db = done_cnt; rb = re_cnt; bb = busy_cnt;
      if (vecs[r].af) begin
        af_run = 1'b1;
        fork af_drive(); join_none
      end
      start_op(vecs[r].len, s);
      wait_done(db + 1, vecs[r].name);
      af_run = 1'b0;
      repeat (8) tick();
      check_lines(vecs[r].name, gb, vecs[r].len, head_seq);
      chk({vecs[r].name, "_ndone"}, 64'(done_cnt - db), 64'd1);
      chk({vecs[r].name, "_nre"}, 64'(re_cnt - rb), 64'(vecs[r].len));
      chk({vecs[r].name, "_busy"}, 64'(busy_cnt - bb > 0), 64'(vecs[r].len != 0));
      if (vecs[r].exp_done >= 0)
        chk({vecs[r].name, "_done_lat"}, 64'(done_cyc - s), 64'(vecs[r].exp_done));
      if (vecs[r].exp_first >= 0 && got_q.size() > gb) begin
        chk({vecs[r].name, "_first_lat"}, 64'(got_cyc[gb] - s), 64'(vecs[r].exp_first));
        chk({vecs[r].name, "_last_lat"}, 64'(got_cyc[got_cyc.size() - 1] - s),
            64'(vecs[r].exp_first + vecs[r].len - 1));
      end
      if (vecs[r].len > 0 && got_q.size() > gb)
        chk({vecs[r].name, "_done_after_last"}, 64'(done_cyc - got_cyc[got_cyc.size() - 1]), 64'd1);
      head_seq += vecs[r].len;
    end

    // FIFO runs dry after two lines; the rest arrive 20 cycles later.
    push_lines(2);
    tick();
    gb = got_q.size(); db = done_cnt;
    start_op(4, s);
    repeat (19) tick();
    chk("stall_nlines_mid", 64'(got_q.size() - gb), 64'd2);
    chk("stall_busy_mid", 64'(busy), 64'd1);
    chk("stall_no_done_mid", 64'(done_cnt - db), 64'd0);
    push_lines(2);
    wait_done(db + 1, "stall");
    repeat (5) tick();
    check_lines("stall", gb, 4, head_seq);
    if (got_q.size() > gb)
      chk("stall_done_after_last", 64'(done_cyc - got_cyc[got_cyc.size() - 1]), 64'd1);
    head_seq += 4;

    // Reset mid-operation aborts without op_done.
    push_lines(10);
    tick();
    db = done_cnt;
    start_op(10, s);
    repeat (5) tick();
    reset = 1'b0;
    #1;
    chk("midrst_fifo_re", 64'(fifo_re), 64'd0);
    chk("midrst_out_we", 64'(out_we), 64'd0);
    chk("midrst_op_done", 64'(op_done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wdata", out_wdata, 64'd0);
    chk("midrst_state", 64'(dut.state), 64'(STATE_IDLE));
    repeat (3) tick();
    reset = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    head_seq = next_seq;
    repeat (5) tick();
    chk("midrst_no_done", 64'(done_cnt - db), 64'd0);
    push_lines(2);
    tick();
    gb = got_q.size(); db = done_cnt;
    start_op(2, s);
    wait_done(db + 1, "postrst");
    repeat (5) tick();
    check_lines("postrst", gb, 2, head_seq);
    head_seq += 2;

    // A second op_start while busy must be ignored.
    push_lines(9);
    tick();
    gb = got_q.size(); db = done_cnt; rb = re_cnt;
    start_op(5, s);
    tick();
    start_op(9, s2);
    wait_done(db + 1, "restart");
    repeat (12) tick();
    check_lines("restart", gb, 5, head_seq);
    chk("restart_ndone", 64'(done_cnt - db), 64'd1);
    chk("restart_nre", 64'(re_cnt - rb), 64'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    head_seq = next_seq;

    // Next op_start in the very cycle op_done is up is accepted.
    push_lines(6);
    tick();
    gb = got_q.size(); db = done_cnt;
    start_op(3, s);
    n = 0;
    while (!op_done && n < 100) begin
      tick();
      n++;
    end
    chk("b2b_done1_seen", 64'(op_done), 64'd1);
    start_op(3, s2);
    wait_done(db + 2, "b2b");
    repeat (5) tick();
    check_lines("b2b", gb, 6, head_seq);
    if (got_q.size() >= gb + 4)
      chk("b2b_second_first_lat", 64'(got_cyc[gb + 3] - s2), 64'd4);
    chk("b2b_ndone", 64'(done_cnt - db), 64'd2);
    head_seq += 6;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
